vocab_matcher: RTL and testbench

Searches a null-terminated vocabulary stored in an external single-port SRAM for an input word, and reports whether the word is present, its token index and its start address. It is the parametrised successor of the single-word matcher. New over that block: a programmable address window, a token index, a start/done handshake, an abort input, and a latched word of up to MAX_WORD_LEN bytes. It sits between the tokenizer front end and the vocab SRAM, which has 1-cycle read latency.

---
 rtl/vocab_matcher.sv | 225 ++++++++++++++++++++++
 tb/tb_vocab_matcher.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vocab_matcher.sv
`default_nettype none
// ============================================================================
// Module   : vocab_matcher
// Purpose  : Searches a null-terminated vocabulary held in an external
//            single-port SRAM (1-cycle read latency) for a latched input word.
//            Reports whether the word is present, its zero-based token index
//            and the start address of the matching entry.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start, abort        - start request (idle only), search cancel
//            word_in             - up to MAX_WORD_LEN bytes, byte 0 in LSBs,
//                                  first zero byte terminates the word
//            start_addr/end_addr - vocab window [start_addr, end_addr)
//            vocab_rd/addr/data  - SRAM read port
//            busy, done          - status, one-cycle completion pulse
//            found, token_idx,
//            match_addr          - result, held until the next completion
// Revision : 1.0 - initial release
// ============================================================================
module vocab_matcher #(
    parameter int ADDR_WIDTH   = 8,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_WORD_LEN = 8,
    parameter int TOKEN_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               abort,
    input  logic [MAX_WORD_LEN*DATA_WIDTH-1:0] word_in,
    input  logic [ADDR_WIDTH-1:0]              start_addr,
    input  logic [ADDR_WIDTH:0]                end_addr,
    output logic                               vocab_rd,
    output logic [ADDR_WIDTH-1:0]              vocab_addr,
    input  logic [DATA_WIDTH-1:0]              vocab_data,
    output logic                               busy,
    output logic                               done,
    output logic                               found,
    output logic [TOKEN_WIDTH-1:0]             token_idx,
    output logic [ADDR_WIDTH-1:0]              match_addr
);

    localparam int C_IDX_W = $clog2(MAX_WORD_LEN + 1);

    localparam logic [2:0] C_ST_IDLE = 3'd0;
    localparam logic [2:0] C_ST_RD   = 3'd1;
    localparam logic [2:0] C_ST_CMP  = 3'd2;
    localparam logic [2:0] C_ST_SRD  = 3'd3;
    localparam logic [2:0] C_ST_SCMP = 3'd4;

    logic [2:0]                        state_q,      state_d;
    logic [ADDR_WIDTH:0]               ptr_q,        ptr_d;
    logic [ADDR_WIDTH:0]               end_q,        end_d;
    logic [ADDR_WIDTH-1:0]             entry_q,      entry_d;
    logic [C_IDX_W-1:0]                i_q,          i_d;
    logic [TOKEN_WIDTH-1:0]            tok_q,        tok_d;
    logic [MAX_WORD_LEN*DATA_WIDTH-1:0] wreg_q,      wreg_d;
    logic                              busy_q,       busy_d;
    logic                              done_q,       done_d;
    logic                              found_q,      found_d;
    logic [TOKEN_WIDTH-1:0]            token_idx_q,  token_idx_d;
    logic [ADDR_WIDTH-1:0]             match_addr_q, match_addr_d;

    logic [DATA_WIDTH-1:0]             w_byte;
    logic [ADDR_WIDTH:0]               w_ptr_inc;
    logic                              w_at_end;
    logic                              w_finish;
    logic                              w_hit;
    logic                              w_next;

    // Current word byte; the position one past the last byte reads as the
    // terminator so a full-length word still needs the entry's 0x00.
    always_comb begin
        w_byte = '0;
        for (int k = 0; k < MAX_WORD_LEN; k++) begin
            if (i_q == C_IDX_W'(k)) begin
                w_byte = wreg_q[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_ptr_inc = ptr_q + (ADDR_WIDTH+1)'(1);
    assign w_at_end  = (ptr_q == end_q);

    // Read strobe is decoded straight from the state so the SRAM sees the
    // address in the same cycle the read is decided.
    assign vocab_rd   = ((state_q == C_ST_RD) || (state_q == C_ST_SRD)) && !w_at_end;
    assign vocab_addr = vocab_rd ? ptr_q[ADDR_WIDTH-1:0] : '0;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        end_d        = end_q;
        entry_d      = entry_q;
        i_d          = i_q;
        tok_d        = tok_q;
        wreg_d       = wreg_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        found_d      = found_q;
        token_idx_d  = token_idx_q;
        match_addr_d = match_addr_q;
        w_finish     = 1'b0;
        w_hit        = 1'b0;
        w_next       = 1'b0;

        if (busy_q && abort) begin
            // Cancel wins over any completion decided this cycle.
            state_d = C_ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                C_ST_IDLE: begin
                    if (start && !abort) begin
                        wreg_d  = word_in;
                        ptr_d   = {1'b0, start_addr};
                        entry_d = start_addr;
                        end_d   = end_addr;
                        i_d     = '0;
                        tok_d   = '0;
                        busy_d  = 1'b1;
                        state_d = C_ST_RD;
                    end
                end
                C_ST_RD, C_ST_SRD: begin
                    if (w_at_end) begin
                        w_finish = 1'b1;
                    end else begin
                        state_d = (state_q == C_ST_RD) ? C_ST_CMP : C_ST_SCMP;
                    end
                end
                C_ST_CMP: begin
                    if (vocab_data == w_byte) begin
                        if (vocab_data == '0) begin
                            w_finish = 1'b1;
                            w_hit    = 1'b1;
                        end else begin
                            ptr_d   = w_ptr_inc;
                            i_d     = i_q + C_IDX_W'(1);
                            state_d = C_ST_RD;
                        end
                    end else if (vocab_data == '0) begin
                        w_next = 1'b1;
                    end else begin
                        // Mismatch inside the entry: skip to its terminator.
                        ptr_d   = w_ptr_inc;
                        state_d = C_ST_SRD;
                    end
                end
                C_ST_SCMP: begin
                    if (vocab_data == '0) begin
                        w_next = 1'b1;
                    end else begin
                        ptr_d   = w_ptr_inc;
                        state_d = C_ST_SRD;
                    end
                end
                default: begin
                    state_d = C_ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase

            if (w_next) begin
                // Token index saturates: running past the last index ends
                // the search as not-found rather than wrapping.
                if (&tok_q) begin
                    w_finish = 1'b1;
                end else begin
                    ptr_d   = w_ptr_inc;
                    entry_d = w_ptr_inc[ADDR_WIDTH-1:0];
                    i_d     = '0;
                    tok_d   = tok_q + TOKEN_WIDTH'(1);
                    state_d = C_ST_RD;
                end
            end

            if (w_finish) begin
                state_d      = C_ST_IDLE;
                busy_d       = 1'b0;
                done_d       = 1'b1;
                found_d      = w_hit;
                token_idx_d  = w_hit ? tok_q   : '0;
                match_addr_d = w_hit ? entry_q : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= C_ST_IDLE;
            ptr_q        <= '0;
            end_q        <= '0;
            entry_q      <= '0;
            i_q          <= '0;
            tok_q        <= '0;
            wreg_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            found_q      <= 1'b0;
            token_idx_q  <= '0;
            match_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            end_q        <= end_d;
            entry_q      <= entry_d;
            i_q          <= i_d;
            tok_q        <= tok_d;
            wreg_q       <= wreg_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            found_q      <= found_d;
            token_idx_q  <= token_idx_d;
            match_addr_q <= match_addr_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign found      = found_q;
    assign token_idx  = token_idx_q;
    assign match_addr = match_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_vocab_matcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_vocab_matcher
// Purpose  : Scoreboard bench for vocab_matcher. A driver issues searches and
//            pushes the reference-model outcome; a monitor pops and compares
//            on every done pulse. Directed cases plus randomized vocabularies.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vocab_matcher;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [63:0] word_in = '0;
    logic [7:0]  start_addr = '0;
    logic [8:0]  end_addr = '0;
    logic        vocab_rd;
    logic [7:0]  vocab_addr;
    logic [7:0]  vocab_data = '0;
    logic        busy, done, found;
    logic [7:0]  token_idx, match_addr;

    vocab_matcher #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_WORD_LEN(8), .TOKEN_WIDTH(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .word_in(word_in), .start_addr(start_addr), .end_addr(end_addr),
        .vocab_rd(vocab_rd), .vocab_addr(vocab_addr), .vocab_data(vocab_data),
        .busy(busy), .done(done), .found(found),
        .token_idx(token_idx), .match_addr(match_addr)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:255];
    always @(posedge clk) if (vocab_rd) vocab_data <= mem[vocab_addr];

    int ecnt = 0;
    always @(posedge clk) ecnt <= ecnt + 1;

    typedef struct {
        bit found;
        int tok;
        int addr;
        int dcyc;
        int reads;
        int done_edge;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    bit   last_found = 0;
    int   last_tok = 0;
    int   last_addr = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] mkword(string s);
        logic [63:0] r = '0;
        for (int k = 0; k < s.len() && k < 8; k++) r[8*k +: 8] = s[k];
        return r;
    endfunction

    // '.' in the string stands for a 0x00 terminator.
    task automatic put(int a, string s);
        for (int k = 0; k < s.len(); k++) mem[a+k] = (s[k] == 8'h2E) ? 8'h00 : s[k];
    endtask

    // Entry-level reference: walk entries, compare whole strings, and count
    // the bytes a byte-serial searcher has to read to reach the verdict.
    function automatic exp_t model(logic [63:0] w, int sa, int ea);
        exp_t r;
        byte unsigned wb[$];
        int addr, tok, nb, len;
        bit same;
        r.found = 0; r.tok = 0; r.addr = 0; r.dcyc = 0; r.reads = 0; r.done_edge = 0;
        for (int k = 0; k < 8; k++) begin
            if (w[8*k +: 8] == 8'h00) break;
            wb.push_back(w[8*k +: 8]);
        end
        addr = sa; tok = 0; nb = 0;
        while (1) begin
            if (addr == ea) begin
                r.dcyc = 2*nb + 1; r.reads = nb; return r;
            end
            len = 0;
            while (addr + len < ea && mem[addr+len] != 8'h00) len++;
            if (addr + len >= ea) begin
                nb += len; addr = ea;
            end else begin
                nb += len + 1;
                same = (len == wb.size());
                for (int k = 0; k < len && same; k++) if (mem[addr+k] != wb[k]) same = 0;
                if (same) begin
                    r.found = 1; r.tok = tok; r.addr = addr;
                    r.dcyc = 2*nb; r.reads = nb; return r;
                end
                if (tok == 255) begin
                    r.dcyc = 2*nb; r.reads = nb; return r;
                end
                tok++; addr += len + 1;
            end
        end
        return r;
    endfunction

    task automatic issue(logic [63:0] w, int sa, int ea, bit stray);
        exp_t e;
        int n;
        @(negedge clk);
        e = model(w, sa, ea);
        e.done_edge = ecnt + 1 + e.dcyc;
        sbq.push_back(e);
        word_in = w; start_addr = sa[7:0]; end_addr = ea[8:0]; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (stray) begin
            repeat (2) @(negedge clk);
            word_in = mkword("cat"); start_addr = 8'd0; end_addr = 9'd11; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (sbq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++; errors++;
            $display("FAIL timeout: done not seen, %0d results pending, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor: counts SRAM reads of the running search and checks every
    // done pulse against the oldest expected result.
    int rdcnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                rdcnt = 0;
            end else begin
                if (vocab_rd) rdcnt++;
                if (done) begin
                    if (sbq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_done: got done=1 expected done=0");
                    end else begin
                        e = sbq.pop_front();
                        chk("done_cycle", ecnt, e.done_edge);
                        chk("found", found, e.found);
                        chk("token_idx", token_idx, e.tok);
                        chk("match_addr", match_addr, e.addr);
                        chk("reads", rdcnt, e.reads);
                        chk("busy_at_done", busy, 0);
                        last_found = e.found; last_tok = e.tok; last_addr = e.addr;
                    end
                    rdcnt = 0;
                end else if (!busy) begin
                    rdcnt = 0;
                end
            end
        end
    end

    initial begin
        int sa, ea, p, len;
        logic [63:0] w;
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;

        // Reset state
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_token_idx", token_idx, 0);
        chk("rst_match_addr", match_addr, 0);
        chk("rst_vocab_rd", vocab_rd, 0);
        chk("rst_vocab_addr", vocab_addr, 0);
        @(negedge clk); rst_n = 1'b1;

        put(0, "cat.dog.do.");
        issue(mkword("do"), 0, 11, 0);
        issue(mkword("dog"), 0, 11, 1);

        // Abort in cycle 5: idle in cycle 6, no done, results held
        @(negedge clk);
        word_in = mkword("do"); start_addr = 8'd0; end_addr = 9'd11; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_vocab_rd", vocab_rd, 0);
        chk("abort_found_held", found, last_found);
        chk("abort_tok_held", token_idx, last_tok);
        chk("abort_addr_held", match_addr, last_addr);
        @(negedge clk); abort = 1'b0;
        repeat (30) @(negedge clk);

        issue(mkword("cat"), 0, 11, 0);
        issue(mkword("ca"), 0, 11, 0);
        issue(mkword("cow"), 0, 11, 0);
        issue(mkword("do"), 5, 5, 0);

        put(249, "qq.xyz.");
        issue(mkword("xyz"), 249, 256, 0);

        put(20, "abcdefgh.");
        put(40, "abcdefghi.");
        issue(mkword("abcdefgh"), 20, 29, 0);
        issue(mkword("abcdefgh"), 40, 50, 0);

        put(100, "ab..x.");
        issue(64'd0, 100, 106, 0);

        // 256 empty entries: token index runs out before the window does
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        issue(mkword("a"), 0, 256, 0);

        // Randomized vocabularies, windows and words
        for (int it = 0; it < 40; it++) begin
            p = 0;
            while (p < 256) begin
                len = $urandom_range(0, 4);
                for (int k = 0; k < len && p < 256; k++) begin
                    mem[p] = 8'h61 + 8'($urandom_range(0, 1));
                    p++;
                end
                if (p < 256) begin mem[p] = 8'h00; p++; end
            end
            sa = $urandom_range(0, 200);
            ea = (it % 8 == 7) ? 256 : sa + $urandom_range(0, 55);
            w = '0;
            if ($urandom_range(0, 1) == 1 && ea > sa) begin
                p = $urandom_range(sa, ea - 1);
                for (int k = 0; k < 8 && p + k < 256; k++) begin
                    if (mem[p+k] == 8'h00) break;
                    w[8*k +: 8] = mem[p+k];
                end
            end else begin
                len = $urandom_range(0, 8);
                for (int k = 0; k < len; k++) w[8*k +: 8] = 8'h61 + 8'($urandom_range(0, 1));
            end
            issue(w, sa, ea, 0);
        end

        // Asynchronous reset in the middle of a search
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;
        put(0, "cat.dog.do.");
        issue(mkword("do"), 0, 11, 0);
        @(negedge clk);
        word_in = mkword("dog"); start_addr = 8'd0; end_addr = 9'd11; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_found", found, 0);
        chk("arst_token_idx", token_idx, 0);
        chk("arst_match_addr", match_addr, 0);
        chk("arst_vocab_rd", vocab_rd, 0);
        chk("arst_vocab_addr", vocab_addr, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
